// File: rtl/enigma_pkg.sv
// Shared types and constants for the enigma rotor sequencing controller.
package enigma_pkg;

  localparam logic [7:0] CHAR_A   = 8'h41;
  localparam logic [7:0] CHAR_Z   = 8'h5A;
  localparam logic [7:0] ERR_CHAR = 8'h3F;
  localparam int         ALPHA    = 26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_STEP,
    S_ISSUE,
    S_WAIT,
    S_BYPASS,
    S_OUT
  } state_t;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= CHAR_A) && (c <= CHAR_Z);
  endfunction

  function automatic logic [4:0] pos_inc(input logic [4:0] p);
    return (p == 5'(ALPHA - 1)) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic [2:0] k_onehot(input logic [1:0] k);
    return 3'b001 << k;
  endfunction

endpackage

// File: rtl/enigma_stepper.sv
// Odometer for the three rotor positions: step enables from the notch compare
// on the current positions, and the registered position update.
module enigma_stepper
  import enigma_pkg::*;
#(
  parameter int NOTCH0 = 16,
  parameter int NOTCH1 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_step,
  output logic [2:0]  o_en,
  output logic [14:0] o_pos
);

  logic [4:0] r_pos0;
  logic [4:0] r_pos1;
  logic [4:0] r_pos2;

  // Carry is a pure notch compare; the 25 -> 0 wrap never carries by itself.
  always_comb begin
    o_en    = 3'b000;
    o_en[0] = 1'b1;
    o_en[1] = (r_pos0 == 5'(NOTCH0));
    o_en[2] = o_en[1] && (r_pos1 == 5'(NOTCH1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos0 <= 5'd0;
      r_pos1 <= 5'd0;
      r_pos2 <= 5'd0;
    end else if (i_clr) begin
      r_pos0 <= 5'd0;
      r_pos1 <= 5'd0;
      r_pos2 <= 5'd0;
    end else if (i_step) begin
      if (o_en[0]) r_pos0 <= pos_inc(r_pos0);
      if (o_en[1]) r_pos1 <= pos_inc(r_pos1);
      if (o_en[2]) r_pos2 <= pos_inc(r_pos2);
    end
  end

  assign o_pos = {r_pos2, r_pos1, r_pos0};

endmodule

// File: rtl/enigma_ctrl.sv
// Sequencer for three rotors: steps them, routes one character through the
// chain (forward for encode, reverse for decode) and returns the result.
//   state  | meaning
//   IDLE   | ready for a character or a config load
//   CFG    | rot_set pulse, positions cleared
//   STEP   | rot_en pulse, positions advance
//   ISSUE  | rot_valid to rotor k
//   WAIT   | wait for rotor k done, bounded by TIMEOUT
//   BYPASS | non-letter passes through untouched
//   OUT    | result held until out_ready
module enigma_ctrl
  import enigma_pkg::*;
#(
  parameter int NROT    = 3,
  parameter int TIMEOUT = 64,
  parameter int NOTCH0  = 16,
  parameter int NOTCH1  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_load,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic        in_dec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic        err,
  output logic [14:0] pos,
  output logic [2:0]  rot_set,
  output logic [2:0]  rot_en,
  output logic [2:0]  rot_valid,
  output logic [7:0]  rot_din,
  output logic        rot_dec,
  input  logic [23:0] rot_dout,
  input  logic [2:0]  rot_done
);

  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [1:0]     K_LAST  = 2'(NROT - 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic [7:0]    r_char;
  logic          r_dec;
  logic [1:0]    r_k;
  logic [CW-1:0] r_cnt;

  logic [2:0]    w_en;
  logic          w_clr;
  logic          w_step;
  logic          w_done;
  logic [7:0]    w_dout;
  logic [1:0]    w_k_next;
  logic          w_last;

  assign w_clr  = (r_state == S_CFG);
  assign w_step = (r_state == S_STEP);

  enigma_stepper #(
    .NOTCH0 (NOTCH0),
    .NOTCH1 (NOTCH1)
  ) u_stepper (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_clr  (w_clr),
    .i_step (w_step),
    .o_en   (w_en),
    .o_pos  (pos)
  );

  assign in_ready = (r_state == S_IDLE);

  // Only the selected rotor's done/dout are observed.
  always_comb begin
    w_done = rot_done[0];
    w_dout = rot_dout[7:0];
    case (r_k)
      2'd1: begin
        w_done = rot_done[1];
        w_dout = rot_dout[15:8];
      end
      2'd2: begin
        w_done = rot_done[2];
        w_dout = rot_dout[23:16];
      end
      default: ;
    endcase
  end

  assign w_k_next = r_dec ? (r_k - 2'd1) : (r_k + 2'd1);
  assign w_last   = r_dec ? (r_k == 2'd0) : (r_k == K_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_char    <= 8'h00;
      r_dec     <= 1'b0;
      r_k       <= 2'd0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      err       <= 1'b0;
      rot_set   <= 3'b000;
      rot_en    <= 3'b000;
      rot_valid <= 3'b000;
      rot_din   <= 8'h00;
      rot_dec   <= 1'b0;
    end else begin
      rot_set   <= 3'b000;
      rot_en    <= 3'b000;
      rot_valid <= 3'b000;
      err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_load) begin
            rot_set <= 3'b111;
            r_state <= S_CFG;
          end else if (in_valid) begin
            r_char <= in_char;
            r_dec  <= in_dec;
            if (is_letter(in_char)) begin
              rot_en  <= w_en;
              r_k     <= in_dec ? K_LAST : 2'd0;
              r_state <= S_STEP;
            end else begin
              r_state <= S_BYPASS;
            end
          end
        end
        S_CFG: r_state <= S_IDLE;
        S_STEP: begin
          rot_valid <= k_onehot(r_k);
          rot_din   <= r_char;
          rot_dec   <= r_dec;
          r_state   <= S_ISSUE;
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done) begin
            r_char <= w_dout;
            if (w_last) begin
              out_char  <= w_dout;
              out_valid <= 1'b1;
              r_state   <= S_OUT;
            end else begin
              r_k       <= w_k_next;
              rot_valid <= k_onehot(w_k_next);
              rot_din   <= w_dout;
              rot_dec   <= r_dec;
              r_state   <= S_ISSUE;
            end
          end else if (r_cnt == CNT_MAX) begin
            err       <= 1'b1;
            r_char    <= ERR_CHAR;
            out_char  <= ERR_CHAR;
            out_valid <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BYPASS: begin
          out_char  <= r_char;
          out_valid <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_ctrl.sv
// Directed bench for enigma_ctrl with behavioural rotors (din + delta, fixed latency).
module tb_enigma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_load = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic        in_dec = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_char;
  logic        err;
  logic [14:0] pos;
  logic [2:0]  rot_set;
  logic [2:0]  rot_en;
  logic [2:0]  rot_valid;
  logic [7:0]  rot_din;
  logic        rot_dec;
  logic [23:0] rot_dout;
  logic [2:0]  rot_done = 3'b000;

  enigma_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_load  (cfg_load),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .in_dec    (in_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .err       (err),
    .pos       (pos),
    .rot_set   (rot_set),
    .rot_en    (rot_en),
    .rot_valid (rot_valid),
    .rot_din   (rot_din),
    .rot_dec   (rot_dec),
    .rot_dout  (rot_dout),
    .rot_done  (rot_done)
  );

  always #5 clk = ~clk;

  // Behavioural rotors: latch din+delta on valid, raise done two edges later.
  logic [7:0] tb_delta = 8'h01;
  logic [2:0] done_mask = 3'b111;
  logic [7:0] rd [3] = '{8'h00, 8'h00, 8'h00};
  int         rcnt [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rot_done[i] <= 1'b0;
      if (rot_valid[i]) begin
        rcnt[i] <= 2;
        rd[i]   <= rot_din + tb_delta;
      end else if (rcnt[i] != 0) begin
        rcnt[i] <= rcnt[i] - 1;
        if (rcnt[i] == 1 && done_mask[i]) rot_done[i] <= 1'b1;
      end
    end
  end

  assign rot_dout = {rd[2], rd[1], rd[0]};

  // Activity monitor sampled on the falling edge.
  int          cyc = 0;
  logic [11:0] vlog = '0;
  logic [2:0]  declog = '0;
  int          v_cnt = 0;
  logic [2:0]  last_en = '0;
  int          en_cnt = 0;
  int          set_cnt = 0;
  int          err_cnt = 0;
  int          err_cyc = 0;
  int          v1_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rot_valid != 3'b000) begin
      vlog   <= {vlog[8:0], rot_valid};
      declog <= {declog[1:0], rot_dec};
      v_cnt  <= v_cnt + 1;
    end
    if (rot_en != 3'b000) begin
      last_en <= rot_en;
      en_cnt  <= en_cnt + 1;
    end
    if (rot_set != 3'b000) set_cnt <= set_cnt + 1;
    if (rot_valid[1]) v1_cyc <= cyc;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Called and returns at a falling edge.
  task automatic xfer(input logic [7:0] c, input logic d, input int hold,
                      output logic [7:0] res, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_char  = c;
    in_dec   = d;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_budget", 32'(out_valid), 32'd1);
    res = out_char;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_char", 32'(out_char), 32'(res));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_cfg();
    cfg_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b0;
    chk("cfg_rot_set_on", 32'(rot_set), 32'h7);
    @(negedge clk);
    chk("cfg_rot_set_off", 32'(rot_set), 32'h0);
    chk("cfg_pos", 32'(pos), 32'h0);
    chk("cfg_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [7:0] res;
  int         lat;
  int         snap_en;
  int         snap_v;
  int         snap_set;
  int         snap_err;
  logic [14:0] snap_pos;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outs", {out_valid, err, rot_dec, rot_set, rot_en, rot_valid}, 32'd0);
    chk("rst_out_char", 32'(out_char), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    snap_set = set_cnt;
    do_cfg();
    @(negedge clk);
    chk("cfg_single_pulse", 32'(set_cnt - snap_set), 32'd1);

    // Encode 'A' through +1 rotors.
    tb_delta = 8'h01;
    xfer(8'h41, 1'b0, 0, res, lat);
    chk("enc_out", 32'(res), 32'h44);
    chk("enc_order", 32'(vlog[8:0]), 32'b001_010_100);
    chk("enc_pos", 32'(pos), 32'd1);
    chk("enc_en", 32'(last_en), 32'b001);

    // Decode 'D' through -1 rotors.
    tb_delta = 8'hFF;
    xfer(8'h44, 1'b1, 0, res, lat);
    chk("dec_out", 32'(res), 32'h41);
    chk("dec_order", 32'(vlog[8:0]), 32'b100_010_001);
    chk("dec_rot_dec", 32'(declog), 32'b111);
    chk("dec_pos", 32'(pos), 32'd2);

    // Carry chain from cleared positions.
    do_cfg();
    tb_delta = 8'h01;
    for (int n = 1; n <= 121; n++) begin
      xfer(8'h41, 1'b0, 0, res, lat);
      if (n == 16) chk("carry_en_16", 32'(last_en), 32'b001);
      if (n == 17) begin
        chk("carry_en_17", 32'(last_en), 32'b011);
        chk("carry_pos_17", 32'(pos), {17'd0, 5'd0, 5'd1, 5'd17});
      end
      if (n == 26) begin
        chk("wrap_en_26", 32'(last_en), 32'b001);
        chk("wrap_pos_26", 32'(pos), {17'd0, 5'd0, 5'd1, 5'd0});
      end
      if (n == 120) chk("pre_notch_pos", 32'(pos), {17'd0, 5'd0, 5'd4, 5'd16});
      if (n == 121) begin
        chk("carry_en_121", 32'(last_en), 32'b111);
        chk("carry_pos_121", 32'(pos), {17'd0, 5'd1, 5'd5, 5'd17});
      end
    end

    // Non-letter bypass.
    snap_en  = en_cnt;
    snap_v   = v_cnt;
    snap_pos = pos;
    xfer(8'h61, 1'b0, 0, res, lat);
    chk("byp_out", 32'(res), 32'h61);
    chk("byp_lat", 32'(lat), 32'd2);
    chk("byp_no_en", 32'(en_cnt - snap_en), 32'd0);
    chk("byp_no_valid", 32'(v_cnt - snap_v), 32'd0);
    chk("byp_pos", 32'(pos), 32'(snap_pos));

    // Output back-pressure for 5 cycles.
    xfer(8'h43, 1'b0, 5, res, lat);
    chk("hold_out", 32'(res), 32'h46);

    // Rotor 1 never answers.
    done_mask = 3'b101;
    snap_err  = err_cnt;
    xfer(8'h43, 1'b0, 0, res, lat);
    chk("to_out", 32'(res), 32'h3F);
    chk("to_err_once", 32'(err_cnt - snap_err), 32'd1);
    chk("to_wait_cycles", 32'(err_cyc - v1_cyc), 32'd65);
    chk("to_order", 32'(vlog[5:0]), 32'b001_010);

    // Reset while waiting on rotor 2 in a decode.
    done_mask = 3'b000;
    snap_err  = err_cnt;
    in_char   = 8'h42;
    in_dec    = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_outs", {out_valid, err, rot_dec, rot_set, rot_en, rot_valid}, 32'd0);
    chk("mid_rst_out_char", 32'(out_char), 32'd0);
    chk("mid_rst_din", 32'(rot_din), 32'd0);
    chk("mid_rst_pos", 32'(pos), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("post_rst_no_err", 32'(err_cnt - snap_err), 32'd0);
    chk("post_rst_idle", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
